pe_sequencer: RTL and testbench

- Control FSM that sequences one dot-product job on the Processing_Element (PE).
- Each job: load vector A, load vector B, clear the PE's PC and accumulator, run N MAC beats, then hold the 32-bit result in an output register with a valid/ready handshake.
- Sits between the host/load logic and the PE. Drives all PE control strobes and observes the PE's PC_Counter and DATAOUT; the PE's DATAIN bus does not pass through this block.

---
 rtl/pe_pkg.sv | 16 +
 rtl/pe_seq_perf.sv | 53 +++++
 rtl/pe_sequencer.sv | 169 ++++++++++++++++
 tb/tb_pe_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and constants for the PE sequencer and its optional performance counters.
package pe_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        CLEAR   = 3'd3,
        MAC     = 3'd4,
        CAPTURE = 3'd5,
        RESP    = 3'd6
    } pe_seq_state_t;

endpackage

// File: rtl/pe_seq_perf.sv
// Job and load-stall counters observed from the sequencer state; both wrap at 2^32.
import pe_pkg::*;

module pe_seq_perf (
    input  logic              CLK,
    input  logic              RSTN,
    input  pe_seq_state_t     state_i,
    input  logic              a_valid_i,
    input  logic              b_valid_i,
    input  logic              result_ready_i,
    output logic [DATA_W-1:0] perf_jobs_o,
    output logic [DATA_W-1:0] perf_stall_o
);

    logic [DATA_W-1:0] jobs_q;
    logic [DATA_W-1:0] jobs_d;
    logic [DATA_W-1:0] stall_q;
    logic [DATA_W-1:0] stall_d;
    logic              job_done_s;
    logic              stall_s;

    // Event decode and counter next-state
    always_comb begin
        job_done_s = (state_i == RESP) && result_ready_i;
        stall_s    = ((state_i == LOAD_A) && !a_valid_i) ||
                     ((state_i == LOAD_B) && !b_valid_i);
        if (job_done_s) begin
            jobs_d = jobs_q + DATA_W'(1);
        end else begin
            jobs_d = jobs_q;
        end
        if (stall_s) begin
            stall_d = stall_q + DATA_W'(1);
        end else begin
            stall_d = stall_q;
        end
    end

    // Counter registers
    always_ff @(posedge CLK) begin
        if (RSTN) begin
            jobs_q  <= '0;
            stall_q <= '0;
        end else begin
            jobs_q  <= jobs_d;
            stall_q <= stall_d;
        end
    end

    assign perf_jobs_o  = jobs_q;
    assign perf_stall_o = stall_q;

endmodule

// File: rtl/pe_sequencer.sv
// Control FSM sequencing one dot-product job on the PE: load A, load B, clear, N MAC beats, capture, respond.
// Build macro PE_SEQ_PERF_EN adds the PERF_JOBS / PERF_STALL counter outputs.
import pe_pkg::*;

module pe_sequencer #(
    parameter int N   = 16,
    parameter int PCW = $clog2(N)
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              START,
    input  logic              A_VALID,
    output logic              A_READY,
    input  logic              B_VALID,
    output logic              B_READY,
    input  logic [PCW-1:0]    PC_Counter,
    input  logic [DATA_W-1:0] DATAOUT,
    output logic              WRITE_MAT,
    output logic              MAT_MUX,
    output logic              RST_MUL,
    output logic              INC_PC,
    output logic              MAC_CTRL,
    output logic              BUSY,
    output logic [DATA_W-1:0] RESULT,
    output logic              RESULT_VALID,
    input  logic              RESULT_READY
`ifdef PE_SEQ_PERF_EN
    ,
    output logic [DATA_W-1:0] PERF_JOBS,
    output logic [DATA_W-1:0] PERF_STALL
`endif
);

    localparam logic [PCW-1:0] LAST_PC = PCW'(N - 1);

    pe_seq_state_t     state_q;
    pe_seq_state_t     state_d;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] result_d;
    logic              a_ready_s;
    logic              b_ready_s;
    logic              write_mat_s;
    logic              mat_mux_s;
    logic              rst_mul_s;
    logic              inc_pc_s;
    logic              mac_ctrl_s;

    // Next-state and PE strobe decode
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        a_ready_s   = 1'b0;
        b_ready_s   = 1'b0;
        write_mat_s = 1'b0;
        mat_mux_s   = 1'b0;
        rst_mul_s   = 1'b0;
        inc_pc_s    = 1'b0;
        mac_ctrl_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = LOAD_A;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_A: begin
                a_ready_s   = 1'b1;
                mat_mux_s   = 1'b1;
                write_mat_s = A_VALID;
                if (A_VALID) begin
                    state_d = LOAD_B;
                end else begin
                    state_d = LOAD_A;
                end
            end
            LOAD_B: begin
                b_ready_s   = 1'b1;
                mat_mux_s   = 1'b0;
                write_mat_s = B_VALID;
                if (B_VALID) begin
                    state_d = CLEAR;
                end else begin
                    state_d = LOAD_B;
                end
            end
            CLEAR: begin
                rst_mul_s = 1'b1;
                state_d   = MAC;
            end
            MAC: begin
                mac_ctrl_s = 1'b1;
                inc_pc_s   = 1'b1;
                // The beat at PC N-1 is the last; whatever the PE PC does next is ignored.
                if (PC_Counter == LAST_PC) begin
                    state_d = CAPTURE;
                end else begin
                    state_d = MAC;
                end
            end
            CAPTURE: begin
                result_d = DATAOUT;
                state_d  = RESP;
            end
            RESP: begin
                if (RESULT_READY) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any job in flight
    always_ff @(posedge CLK) begin
        if (RSTN) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    // Output drive: while reset is held only the PE clear strobe is active
    always_comb begin
        if (RSTN) begin
            A_READY      = 1'b0;
            B_READY      = 1'b0;
            WRITE_MAT    = 1'b0;
            MAT_MUX      = 1'b0;
            RST_MUL      = 1'b1;
            INC_PC       = 1'b0;
            MAC_CTRL     = 1'b0;
            BUSY         = 1'b0;
            RESULT_VALID = 1'b0;
        end else begin
            A_READY      = a_ready_s;
            B_READY      = b_ready_s;
            WRITE_MAT    = write_mat_s;
            MAT_MUX      = mat_mux_s;
            RST_MUL      = rst_mul_s;
            INC_PC       = inc_pc_s;
            MAC_CTRL     = mac_ctrl_s;
            BUSY         = (state_q != IDLE);
            RESULT_VALID = (state_q == RESP);
        end
    end

    assign RESULT = result_q;

`ifdef PE_SEQ_PERF_EN
    pe_seq_perf u_perf (
        .CLK            (CLK),
        .RSTN           (RSTN),
        .state_i        (state_q),
        .a_valid_i      (A_VALID),
        .b_valid_i      (B_VALID),
        .result_ready_i (RESULT_READY),
        .perf_jobs_o    (PERF_JOBS),
        .perf_stall_o   (PERF_STALL)
    );
`endif

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer (N=4) with a behavioural PE model driving PC_Counter and DATAOUT.
module tb_pe_sequencer;

    localparam int N   = 4;
    localparam int PCW = 2;

    logic        CLK;
    logic        RSTN;
    logic        START;
    logic        A_VALID;
    logic        A_READY;
    logic        B_VALID;
    logic        B_READY;
    logic [PCW-1:0] pc_q;
    logic [31:0] acc_q;
    logic        WRITE_MAT;
    logic        MAT_MUX;
    logic        RST_MUL;
    logic        INC_PC;
    logic        MAC_CTRL;
    logic        BUSY;
    logic [31:0] RESULT;
    logic        RESULT_VALID;
    logic        RESULT_READY;
`ifdef PE_SEQ_PERF_EN
    logic [31:0] PERF_JOBS;
    logic [31:0] PERF_STALL;
`endif

    logic [31:0] a_vec [N];
    logic [31:0] b_vec [N];
    logic [31:0] mata  [N];
    logic [31:0] matb  [N];

    int total;
    int bad;

    pe_sequencer #(.N(N)) dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .START        (START),
        .A_VALID      (A_VALID),
        .A_READY      (A_READY),
        .B_VALID      (B_VALID),
        .B_READY      (B_READY),
        .PC_Counter   (pc_q),
        .DATAOUT      (acc_q),
        .WRITE_MAT    (WRITE_MAT),
        .MAT_MUX      (MAT_MUX),
        .RST_MUL      (RST_MUL),
        .INC_PC       (INC_PC),
        .MAC_CTRL     (MAC_CTRL),
        .BUSY         (BUSY),
        .RESULT       (RESULT),
        .RESULT_VALID (RESULT_VALID),
        .RESULT_READY (RESULT_READY)
`ifdef PE_SEQ_PERF_EN
        ,
        .PERF_JOBS    (PERF_JOBS),
        .PERF_STALL   (PERF_STALL)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural PE: whole-vector load on WRITE_MAT, 32-bit wrapping MAC at lane PC
    always @(posedge CLK) begin
        if (RST_MUL) begin
            pc_q  <= '0;
            acc_q <= 32'd0;
        end else begin
            if (MAC_CTRL) acc_q <= acc_q + mata[pc_q] * matb[pc_q];
            if (INC_PC)   pc_q  <= pc_q + PCW'(1);
        end
        if (WRITE_MAT) begin
            for (int i = 0; i < N; i++) begin
                if (MAT_MUX) mata[i] <= a_vec[i];
                else         matb[i] <= b_vec[i];
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drives one job from START until RESULT_VALID rises (or 60 cycles pass) and records what it saw.
    task automatic run_job(input int a_dly, input int b_dly, output int lat, output int a_rdy_cnt,
                           output int mac_cnt, output int wm_cnt, output logic [1:0] wm_mux);
        lat = -1; a_rdy_cnt = 0; mac_cnt = 0; wm_cnt = 0; wm_mux = 2'b00;
        for (int k = 0; k < 60; k++) begin
            step();
            START   = (k == 0);
            A_VALID = (k >= 1 + a_dly);
            B_VALID = (k >= 2 + a_dly + b_dly);
            #1;
            if (A_READY)  a_rdy_cnt++;
            if (MAC_CTRL) mac_cnt++;
            if (WRITE_MAT) begin
                if (wm_cnt < 2) wm_mux[wm_cnt] = MAT_MUX;
                wm_cnt++;
            end
            if (RESULT_VALID) begin
                lat = k;
                break;
            end
        end
        START = 1'b0; A_VALID = 1'b0; B_VALID = 1'b0;
    endtask

    task automatic handshake();
        step();
        RESULT_READY = 1'b1;
        step();
        RESULT_READY = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        step(); step();
        total++;
        if ({RST_MUL, BUSY, RESULT_VALID, A_READY, B_READY, WRITE_MAT, MAT_MUX, INC_PC, MAC_CTRL} !== 9'b1_0000_0000) begin
            bad++; $display("FAIL reset_strobes: got %b want 100000000",
                {RST_MUL, BUSY, RESULT_VALID, A_READY, B_READY, WRITE_MAT, MAT_MUX, INC_PC, MAC_CTRL});
        end
        total++;
        if (RESULT !== 32'd0) begin bad++; $display("FAIL reset_result: got %h want 0", RESULT); end
        step();
        RSTN = 1'b0;
        #1;
        total++;
        if ({RST_MUL, BUSY, A_READY} !== 3'b000) begin
            bad++; $display("FAIL post_reset_idle: got %b want 000", {RST_MUL, BUSY, A_READY});
        end
`ifdef PE_SEQ_PERF_EN
        total++;
        if (PERF_JOBS !== 32'd0 || PERF_STALL !== 32'd0) begin
            bad++; $display("FAIL reset_perf: got %0d/%0d want 0/0", PERF_JOBS, PERF_STALL);
        end
`endif
    endtask

    task automatic test_basic();
        int lat, ar, mc, wc;
        logic [1:0] wm;
        a_vec = '{32'd1, 32'd2, 32'd3, 32'd4};
        b_vec = '{32'd5, 32'd6, 32'd7, 32'd8};
        run_job(0, 0, lat, ar, mc, wc, wm);
        total++;
        if (lat !== 9) begin bad++; $display("FAIL basic_latency: got %0d want 9", lat); end
        total++;
        if (RESULT !== 32'd70) begin bad++; $display("FAIL basic_result: got %0d want 70", RESULT); end
        total++;
        if (mc !== 4) begin bad++; $display("FAIL basic_mac_beats: got %0d want 4", mc); end
        total++;
        if (wc !== 2 || wm !== 2'b01) begin bad++; $display("FAIL basic_writes: got %0d/%b want 2/01", wc, wm); end
        handshake();
        total++;
        if (BUSY !== 1'b0 || RESULT_VALID !== 1'b0) begin
            bad++; $display("FAIL basic_release: got busy=%b valid=%b want 0 0", BUSY, RESULT_VALID);
        end
    endtask

    task automatic test_stall();
        int lat, ar, mc, wc;
        logic [1:0] wm;
        a_vec = '{32'd10, 32'd20, 32'd30, 32'd40};
        b_vec = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_job(3, 2, lat, ar, mc, wc, wm);
        total++;
        if (lat !== 14) begin bad++; $display("FAIL stall_latency: got %0d want 14", lat); end
        total++;
        if (ar !== 4) begin bad++; $display("FAIL stall_a_ready: got %0d want 4", ar); end
        total++;
        if (wc !== 2 || wm !== 2'b01) begin bad++; $display("FAIL stall_writes: got %0d/%b want 2/01", wc, wm); end
        total++;
        if (RESULT !== 32'd300) begin bad++; $display("FAIL stall_result: got %0d want 300", RESULT); end
`ifdef PE_SEQ_PERF_EN
        total++;
        if (PERF_STALL !== 32'd5) begin bad++; $display("FAIL stall_perf: got %0d want 5", PERF_STALL); end
`endif
        handshake();
    endtask

    task automatic test_resp_hold();
        int lat, ar, mc, wc;
        logic [1:0] wm;
        a_vec = '{32'd1, 32'd1, 32'd1, 32'd1};
        b_vec = '{32'd2, 32'd2, 32'd2, 32'd2};
        run_job(0, 0, lat, ar, mc, wc, wm);
        total++;
        if (lat !== 9) begin bad++; $display("FAIL hold_latency: got %0d want 9", lat); end
        for (int i = 0; i < 10; i++) begin
            step();
            START = (i == 3);
            #1;
            total++;
            if (RESULT !== 32'd8 || RESULT_VALID !== 1'b1 || BUSY !== 1'b1) begin
                bad++; $display("FAIL hold_cycle%0d: got res=%0d valid=%b busy=%b want 8 1 1", i, RESULT, RESULT_VALID, BUSY);
            end
        end
        step();
        START = 1'b1;
        RESULT_READY = 1'b1;
        #1;
        total++;
        if (RESULT_VALID !== 1'b1) begin bad++; $display("FAIL hold_accept_valid: got %b want 1", RESULT_VALID); end
        step();
        START = 1'b0;
        RESULT_READY = 1'b0;
        #1;
        total++;
        if (BUSY !== 1'b0 || A_READY !== 1'b0) begin
            bad++; $display("FAIL hold_to_idle: got busy=%b a_ready=%b want 0 0", BUSY, A_READY);
        end
        step();
        total++;
        if (BUSY !== 1'b0) begin bad++; $display("FAIL hold_start_ignored: got busy=%b want 0", BUSY); end
    endtask

    task automatic test_reset_mid_mac();
        int lat, ar, mc, wc;
        logic [1:0] wm;
        bit found;
        found = 1'b0;
        a_vec = '{32'd1, 32'd2, 32'd3, 32'd4};
        b_vec = '{32'd5, 32'd6, 32'd7, 32'd8};
        for (int k = 0; k < 30; k++) begin
            step();
            START = (k == 0); A_VALID = 1'b1; B_VALID = 1'b1;
            #1;
            if (MAC_CTRL === 1'b1 && pc_q === 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        START = 1'b0; A_VALID = 1'b0; B_VALID = 1'b0;
        total++;
        if (!found) begin bad++; $display("FAIL midmac_reach: got no MAC beat at pc=2 want one"); end
        RSTN = 1'b1;
        #1;
        total++;
        if ({RST_MUL, MAC_CTRL, INC_PC, WRITE_MAT, BUSY, RESULT_VALID} !== 6'b100000) begin
            bad++; $display("FAIL midmac_in_reset: got %b want 100000", {RST_MUL, MAC_CTRL, INC_PC, WRITE_MAT, BUSY, RESULT_VALID});
        end
        step();
        RSTN = 1'b0;
        #1;
        total++;
        if (BUSY !== 1'b0 || A_READY !== 1'b0 || RESULT !== 32'd0 || pc_q !== 2'd0) begin
            bad++; $display("FAIL midmac_after: got busy=%b a_ready=%b res=%0d pc=%0d want 0 0 0 0", BUSY, A_READY, RESULT, pc_q);
        end
`ifdef PE_SEQ_PERF_EN
        total++;
        if (PERF_JOBS !== 32'd0) begin bad++; $display("FAIL midmac_perf: got %0d want 0", PERF_JOBS); end
`endif
        a_vec = '{32'd2, 32'd2, 32'd2, 32'd2};
        b_vec = '{32'd3, 32'd3, 32'd3, 32'd3};
        run_job(0, 0, lat, ar, mc, wc, wm);
        total++;
        if (lat !== 9 || RESULT !== 32'd24) begin
            bad++; $display("FAIL midmac_fresh_job: got lat=%0d res=%0d want 9 24", lat, RESULT);
        end
        handshake();
    endtask

    task automatic test_wrap();
        int lat, ar, mc, wc;
        logic [1:0] wm;
        a_vec = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        b_vec = '{32'd2, 32'd2, 32'd0, 32'd0};
        run_job(0, 0, lat, ar, mc, wc, wm);
        total++;
        if (RESULT !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_result: got %h want fffffffc", RESULT); end
        handshake();
    endtask

    task automatic test_back_to_back();
        int lat, ar, mc, wc;
        logic [1:0] wm;
        a_vec = '{32'd1, 32'd2, 32'd3, 32'd4};
        b_vec = '{32'd5, 32'd6, 32'd7, 32'd8};
        run_job(0, 0, lat, ar, mc, wc, wm);
        total++;
        if (lat !== 9 || RESULT !== 32'd70) begin
            bad++; $display("FAIL b2b_job: got lat=%0d res=%0d want 9 70", lat, RESULT);
        end
        handshake();
`ifdef PE_SEQ_PERF_EN
        total++;
        if (PERF_JOBS !== 32'd3) begin bad++; $display("FAIL b2b_perf_jobs: got %0d want 3", PERF_JOBS); end
`endif
        total++;
        if (BUSY !== 1'b0) begin bad++; $display("FAIL b2b_idle: got busy=%b want 0", BUSY); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        RSTN = 1'b1;
        START = 1'b0;
        A_VALID = 1'b0;
        B_VALID = 1'b0;
        RESULT_READY = 1'b0;
        for (int i = 0; i < N; i++) begin
            a_vec[i] = 32'd0;
            b_vec[i] = 32'd0;
        end
        test_reset();
        test_basic();
        test_stall();
        test_resp_hold();
        test_reset_mid_mac();
        test_wrap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
